// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed score display: segment patterns,
// conversion states and BCD sizing helpers.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    // 4 * ceil(val_w*log10(2) + 1), with log10(2) taken as 0.30103
    function automatic int bcd_width(input int val_w);
        return 4 * ((val_w * 30103 + 199999) / 100000);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, result held in
// the upper part of a combined BCD/binary shift register.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VAL_W = 14,
    parameter int BCD_W = bcd_width(VAL_W)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int SR_W  = BCD_W + VAL_W;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam int ND    = BCD_W / 4;

    conv_state_t      state;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt;

    assign bcd = sr[SR_W-1 -: BCD_W];

    // add-3 correction on every BCD nibble ahead of the next shift
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < ND; d++) begin
            if (sr[VAL_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[VAL_W + 4*d +: 4] = sr[VAL_W + 4*d +: 4] + 4'd3;
            end else begin
                sr_adj[VAL_W + 4*d +: 4] = sr[VAL_W + 4*d +: 4];
            end
        end
    end

    // conversion sequencer; done is high for exactly the LOAD cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {{BCD_W{1'b0}}, bin};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(VAL_W - 1)) begin
                        done  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg_score_display.sv
// N-digit common-anode scanner: converts value to BCD on change, blanks
// leading zeros, shows dashes on overflow and blinks on request.
module seg_score_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int VAL_W        = 14,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_BLANK     = 1
) (
    input  logic                  segclk,
    input  logic                  clr,
    input  logic [VAL_W-1:0]      value,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy
);

    localparam int BCD_W  = bcd_width(VAL_W);
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int EXT_W  = (BCD_W > DISP_W) ? BCD_W : DISP_W;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] MSD = IDX_W'(NUM_DIGITS - 1);

    logic [VAL_W-1:0]      last_val;
    logic                  start;
    logic                  done;
    logic [BCD_W-1:0]      bcd;
    logic [EXT_W-1:0]      bcd_ext;
    logic [DISP_W-1:0]     disp;
    logic                  ovf;
    logic                  ovf_nxt;
    logic [IDX_W-1:0]      idx;
    logic [BCNT_W-1:0]     bcnt;
    logic                  phase;
    logic                  phase_eff;
    logic                  nz;
    logic [NUM_DIGITS-1:0] lead;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_nxt;

    assign start     = (value != last_val) && !busy;
    assign bcd_ext   = EXT_W'(bcd);
    assign ovf_nxt   = |(bcd_ext >> DISP_W);
    assign phase_eff = blink_en ? phase : 1'b1;
    assign cur_digit = disp[4*idx +: 4];

    bin2bcd_seq #(
        .VAL_W (VAL_W),
        .BCD_W (BCD_W)
    ) u_conv (
        .clk   (segclk),
        .clr   (clr),
        .start (start),
        .bin   (value),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // remember the value being converted and latch finished results
    always_ff @(posedge segclk or negedge clr) begin
        if (!clr) begin
            last_val <= '0;
            disp     <= '0;
            ovf      <= 1'b0;
        end else begin
            if (start) begin
                last_val <= value;
            end
            if (done) begin
                disp <= bcd_ext[DISP_W-1:0];
                ovf  <= ovf_nxt;
            end
        end
    end

    // lead[d] marks digits at or above d that are all zero
    always_comb begin
        nz   = 1'b0;
        lead = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nz      = nz | (disp[4*d +: 4] != 4'd0);
            lead[d] = ~nz;
        end
    end

    // pattern for the slot about to be driven
    always_comb begin
        if (ovf) begin
            seg_nxt = SEG_DASH;
        end else if ((LZ_BLANK != 0) && (idx != '0) && lead[idx]) begin
            seg_nxt = SEG_BLANK;
        end else begin
            seg_nxt = seg_decode(cur_digit);
        end
    end

    // scan: seg and an update on the same edge, MSD first
    always_ff @(posedge segclk or negedge clr) begin
        if (!clr) begin
            idx <= MSD;
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            idx <= (idx == '0) ? MSD : idx - 1'b1;
            if (phase_eff) begin
                seg <= seg_nxt;
                an  <= ~(NUM_DIGITS'(1) << idx);
            end else begin
                seg <= SEG_BLANK;
                an  <= '1;
            end
        end
    end

    // frame counter; toggling on the LSD edge makes the MSD slot take the new phase
    always_ff @(posedge segclk or negedge clr) begin
        if (!clr) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (!blink_en) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (idx == '0) begin
            if (bcnt == BCNT_W'(BLINK_FRAMES - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end else begin
            bcnt  <= bcnt;
            phase <= phase;
        end
    end

endmodule
